// File: rtl/spi_ram_burst_pkg.sv
// Shared definitions for the SPI-attached burst RAM.
// Contents:
//   control_e       - 2-bit command prefix carried in the top bits of each received word
//   DEFAULT_*       - default data width / depth used by the RAM parameters
//   MAX_RD_LATENCY  - upper bound on the configurable read latency
//   next_addr()     - address increment with wrap at the end of the memory
package spi_ram_burst_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } control_e;

  localparam int unsigned DEFAULT_MEM_WIDTH = 8;
  localparam int unsigned DEFAULT_MEM_DEPTH = 256;
  localparam int unsigned MAX_RD_LATENCY    = 4;

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/spi_ram_rd_pipe.sv
// Read-latency pipeline for the SPI burst RAM.
// A valid/data shift register of RD_LATENCY stages; the last stage drives the transmit path.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   issue       - a read is accepted this cycle
//   issue_data  - memory word for the accepted read
//   tx_valid    - one-cycle pulse when a read leaves the pipeline
//   dout        - read data; holds its last value between pulses
//   busy        - any read in flight
module spi_ram_rd_pipe #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MEM_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue,
  input  logic [MEM_WIDTH-1:0] issue_data,
  output logic                 tx_valid,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 busy
);

  logic [RD_LATENCY-1:0] vld_q;
  logic [MEM_WIDTH-1:0]  dat_q [RD_LATENCY];

  // Data only moves along with a valid bit, so the final stage keeps the last read word
  // while no new read arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      if (issue) dat_q[0] <= issue_data;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign tx_valid = vld_q[RD_LATENCY-1];
  assign dout     = dat_q[RD_LATENCY-1];
  assign busy     = |vld_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Single-port RAM behind the SPI slave with burst addressing and pipelined reads.
// Each received word carries a 2-bit command and a MEM_WIDTH data field.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   rx_valid    - rx_data holds a command this cycle
//   rx_data     - {command, d_in}
//   tx_valid    - one-cycle pulse, dout holds read data
//   dout        - read data
//   addr_err    - one-cycle pulse: address command out of range
//   seq_err     - one-cycle pulse: data command before any address was loaded
//   busy        - reads in the latency pipeline
module spi_ram_burst
  import spi_ram_burst_pkg::*;
#(
  parameter int unsigned MEM_WIDTH  = DEFAULT_MEM_WIDTH,
  parameter int unsigned MEM_DEPTH  = DEFAULT_MEM_DEPTH,
  parameter int unsigned ADDR_SIZE  = $clog2(MEM_DEPTH),
  parameter int unsigned RD_LATENCY = 1,
  parameter bit          AUTO_INC   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [MEM_WIDTH+1:0] rx_data,
  output logic                 tx_valid,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 addr_err,
  output logic                 seq_err,
  output logic                 busy
);

  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
    $error("spi_ram_burst: RD_LATENCY out of range");
  end

  localparam logic [MEM_WIDTH:0] DEPTH_EXT = (MEM_WIDTH+1)'(MEM_DEPTH);

  control_e             cmd;
  logic [MEM_WIDTH-1:0] d_in;
  logic                 in_range;

  assign cmd      = control_e'(rx_data[MEM_WIDTH+1:MEM_WIDTH]);
  assign d_in     = rx_data[MEM_WIDTH-1:0];
  assign in_range = {1'b0, d_in} < DEPTH_EXT;

  logic [ADDR_SIZE-1:0] wr_addr, wr_addr_d, wr_addr_inc;
  logic [ADDR_SIZE-1:0] rd_addr, rd_addr_d, rd_addr_inc;
  logic                 wr_armed, wr_armed_d;
  logic                 rd_armed, rd_armed_d;
  logic                 addr_err_d, seq_err_d;
  logic                 mem_we;
  logic                 rd_issue;

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  assign wr_addr_inc = ADDR_SIZE'(next_addr(32'(wr_addr), MEM_DEPTH));
  assign rd_addr_inc = ADDR_SIZE'(next_addr(32'(rd_addr), MEM_DEPTH));

  always_comb begin
    wr_addr_d  = wr_addr;
    rd_addr_d  = rd_addr;
    wr_armed_d = wr_armed;
    rd_armed_d = rd_armed;
    addr_err_d = 1'b0;
    seq_err_d  = 1'b0;
    mem_we     = 1'b0;
    rd_issue   = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        WR_ADDR: begin
          if (in_range) begin
            wr_addr_d  = ADDR_SIZE'(d_in);
            wr_armed_d = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        WR_DATA: begin
          if (wr_armed) begin
            mem_we = 1'b1;
            if (AUTO_INC) wr_addr_d = wr_addr_inc;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        RD_ADDR: begin
          if (in_range) begin
            rd_addr_d  = ADDR_SIZE'(d_in);
            rd_armed_d = 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        RD_DATA: begin
          if (rd_armed) begin
            rd_issue = 1'b1;
            if (AUTO_INC) rd_addr_d = rd_addr_inc;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      wr_armed <= 1'b0;
      rd_armed <= 1'b0;
      addr_err <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      wr_addr  <= wr_addr_d;
      rd_addr  <= rd_addr_d;
      wr_armed <= wr_armed_d;
      rd_armed <= rd_armed_d;
      addr_err <= addr_err_d;
      seq_err  <= seq_err_d;
    end
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= d_in;
  end

  // Asynchronous array read, registered by the first pipeline stage; a write at one edge is
  // therefore visible to a read accepted at the next.
  spi_ram_rd_pipe #(
    .RD_LATENCY(RD_LATENCY),
    .MEM_WIDTH (MEM_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (rd_issue),
    .issue_data(mem[rd_addr]),
    .tx_valid  (tx_valid),
    .dout      (dout),
    .busy      (busy)
  );

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed self-checking bench for spi_ram_burst.
// Three instances: A (depth 100, latency 1, auto-increment), B (depth 100, latency 3),
// C (depth 256, latency 1, address hold).
module tb_spi_ram_burst;
  import spi_ram_burst_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rxv_a, rxv_b, rxv_c;
  logic [9:0] rxd_a, rxd_b, rxd_c;
  logic       txv_a, txv_b, txv_c;
  logic [7:0] dout_a, dout_b, dout_c;
  logic       ae_a, ae_b, ae_c;
  logic       se_a, se_b, se_c;
  logic       busy_a, busy_b, busy_c;

  int n_cmp  = 0;
  int n_fail = 0;

  spi_ram_burst #(
    .MEM_WIDTH(8), .MEM_DEPTH(100), .RD_LATENCY(1), .AUTO_INC(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_valid(rxv_a), .rx_data(rxd_a), .tx_valid(txv_a),
    .dout(dout_a), .addr_err(ae_a), .seq_err(se_a), .busy(busy_a)
  );

  spi_ram_burst #(
    .MEM_WIDTH(8), .MEM_DEPTH(100), .RD_LATENCY(3), .AUTO_INC(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_valid(rxv_b), .rx_data(rxd_b), .tx_valid(txv_b),
    .dout(dout_b), .addr_err(ae_b), .seq_err(se_b), .busy(busy_b)
  );

  spi_ram_burst #(
    .MEM_WIDTH(8), .MEM_DEPTH(256), .RD_LATENCY(1), .AUTO_INC(1'b0)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .rx_valid(rxv_c), .rx_data(rxd_c), .tx_valid(txv_c),
    .dout(dout_c), .addr_err(ae_c), .seq_err(se_c), .busy(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command for one rising edge, then sample 1 time unit after that edge.
  task automatic send(input int sel, input control_e cmd, input logic [7:0] d);
    case (sel)
      0: begin rxv_a = 1'b1; rxd_a = {cmd, d}; end
      1: begin rxv_b = 1'b1; rxd_b = {cmd, d}; end
      default: begin rxv_c = 1'b1; rxd_c = {cmd, d}; end
    endcase
    @(posedge clk);
    #1;
    rxv_a = 1'b0;
    rxv_b = 1'b0;
    rxv_c = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rxv_a = 1'b0; rxv_b = 1'b0; rxv_c = 1'b0;
    rxd_a = '0;   rxd_b = '0;   rxd_c = '0;
    idle(2);
    rst_n = 1'b1;

    // Reset state
    check("rst_txv_a",  32'(txv_a),  32'd0);
    check("rst_dout_a", 32'(dout_a), 32'd0);
    check("rst_ae_a",   32'(ae_a),   32'd0);
    check("rst_se_a",   32'(se_a),   32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_dout_b", 32'(dout_b), 32'd0);

    // Read data before any read address
    send(0, RD_DATA, 8'h00);
    check("t1_seq_err", 32'(se_a),  32'd1);
    check("t1_addr_err", 32'(ae_a), 32'd0);
    check("t1_no_txv",  32'(txv_a), 32'd0);
    check("t1_rd_addr", 32'(dut_a.rd_addr), 32'd0);
    idle(1);
    check("t1_seq_pulse", 32'(se_a), 32'd0);
    check("t1_no_txv2",   32'(txv_a), 32'd0);

    // Burst write across the wrap, then burst read back
    send(0, WR_ADDR, 8'd98);
    check("t2_wa_ae", 32'(ae_a), 32'd0);
    send(0, WR_DATA, 8'hA1);
    send(0, WR_DATA, 8'hA2);
    send(0, WR_DATA, 8'hA3);
    check("t2_wr_se", 32'(se_a), 32'd0);
    send(0, RD_ADDR, 8'd98);
    check("t2_ra_txv", 32'(txv_a), 32'd0);
    send(0, RD_DATA, 8'h00);
    check("t2_txv0",  32'(txv_a),  32'd1);
    check("t2_dout0", 32'(dout_a), 32'hA1);
    send(0, RD_DATA, 8'h00);
    check("t2_txv1",  32'(txv_a),  32'd1);
    check("t2_dout1", 32'(dout_a), 32'hA2);
    send(0, RD_DATA, 8'h00);
    check("t2_txv2",  32'(txv_a),  32'd1);
    check("t2_dout2", 32'(dout_a), 32'hA3);
    idle(1);
    check("t2_txv_end",  32'(txv_a),  32'd0);
    check("t2_dout_hold", 32'(dout_a), 32'hA3);
    send(0, RD_ADDR, 8'd0);
    send(0, RD_DATA, 8'h00);
    check("t2_wrap_txv",  32'(txv_a),  32'd1);
    check("t2_wrap_mem0", 32'(dout_a), 32'hA3);

    // Address range: 98,99,0 written, so wr_addr is now 1
    send(0, WR_ADDR, 8'd100);
    check("t3_ae_100",  32'(ae_a), 32'd1);
    check("t3_se_100",  32'(se_a), 32'd0);
    check("t3_wa_keep", 32'(dut_a.wr_addr), 32'd1);
    idle(1);
    check("t3_ae_pulse", 32'(ae_a), 32'd0);
    send(0, WR_ADDR, 8'd99);
    check("t3_ae_99", 32'(ae_a), 32'd0);
    check("t3_wa_99", 32'(dut_a.wr_addr), 32'd99);
    send(0, RD_ADDR, 8'd255);
    check("t3_ae_rd255", 32'(ae_a), 32'd1);
    check("t3_ra_keep",  32'(dut_a.rd_addr), 32'd1);

    // Read-after-write on consecutive edges
    send(0, RD_ADDR, 8'd10);
    send(0, WR_ADDR, 8'd10);
    send(0, WR_DATA, 8'h5C);
    send(0, RD_DATA, 8'h00);
    check("raw_txv",  32'(txv_a),  32'd1);
    check("raw_dout", 32'(dout_a), 32'h5C);

    // Address hold (instance C)
    send(2, WR_ADDR, 8'd5);
    send(2, WR_DATA, 8'h11);
    idle(2);
    check("t6_idle_txv", 32'(txv_c), 32'd0);
    check("t6_idle_wa",  32'(dut_c.wr_addr), 32'd5);
    check("t6_idle_se",  32'(se_c), 32'd0);
    send(2, WR_DATA, 8'h22);
    idle(1);
    send(2, RD_ADDR, 8'd5);
    idle(1);
    check("t6_no_txv", 32'(txv_c), 32'd0);
    send(2, RD_DATA, 8'h00);
    check("t6_txv",  32'(txv_c),  32'd1);
    check("t6_dout", 32'(dout_c), 32'h22);
    send(2, RD_DATA, 8'h00);
    check("t6_hold_dout", 32'(dout_c), 32'h22);
    check("t6_hold_ra",   32'(dut_c.rd_addr), 32'd5);

    // Latency 3 (instance B)
    send(1, WR_ADDR, 8'd7);
    send(1, WR_DATA, 8'h3C);
    send(1, WR_DATA, 8'h4D);
    send(1, RD_ADDR, 8'd7);
    send(1, RD_DATA, 8'h00);
    check("t4_n_txv",   32'(txv_b),  32'd0);
    check("t4_n_busy",  32'(busy_b), 32'd1);
    idle(1);
    check("t4_n1_txv",  32'(txv_b),  32'd0);
    check("t4_n1_busy", 32'(busy_b), 32'd1);
    idle(1);
    check("t4_n2_txv",  32'(txv_b),  32'd1);
    check("t4_n2_dout", 32'(dout_b), 32'h3C);
    check("t4_n2_busy", 32'(busy_b), 32'd1);
    idle(1);
    check("t4_n3_txv",  32'(txv_b),  32'd0);
    check("t4_n3_busy", 32'(busy_b), 32'd0);
    check("t4_n3_dout", 32'(dout_b), 32'h3C);

    // Reset with two reads in flight
    send(1, RD_DATA, 8'h00);
    send(1, RD_DATA, 8'h00);
    check("t5_busy_pre", 32'(busy_b), 32'd1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("t5_txv",  32'(txv_b),  32'd0);
    check("t5_dout", 32'(dout_b), 32'd0);
    check("t5_busy", 32'(busy_b), 32'd0);
    idle(1);
    check("t5_txv1", 32'(txv_b), 32'd0);
    idle(1);
    check("t5_txv2", 32'(txv_b), 32'd0);
    check("t5_busy2", 32'(busy_b), 32'd0);
    send(1, WR_DATA, 8'h99);
    check("t5_disarm_se", 32'(se_b), 32'd1);
    check("t5_disarm_ae", 32'(ae_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
